bs_word_serializer: RTL and testbench

- Transmit end of the bit-serial operand interface. Accepts a parallel word (e.g. the 8-bit switch value) over a valid/ready handshake.
- Emits the word one bit per clock, LSB-first, framed by first/last markers. Optional sign- or zero-extension guard bits follow the word, so downstream bit-serial multiply/add units see a full-length operand.
- Sits between the switch/start front end and the bit-serial datapath.

---
 rtl/bs_pkg.sv | 15 +
 rtl/bs_frame_ctr.sv | 33 +++
 rtl/bs_word_serializer.sv | 99 +++++++++
 tb/tb_bs_word_serializer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared types and defaults for the bit-serial operand interface
// (serializer and matching deserializer).
package bs_pkg;

    typedef enum logic {BS_IDLE, BS_SHIFT} bs_ser_state_t;

    localparam int BS_WORD_W  = 8;
    localparam int BS_GUARD_W = 8;

    // Frame counter width; a one-bit floor keeps a degenerate length legal.
    function automatic int bs_ctr_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/bs_frame_ctr.sv
// Bit-position counter for one serial frame of L bits: reload to 0,
// advance on enable, saturate at L-1 and flag the first/last positions.
module bs_frame_ctr
    import bs_pkg::*;
#(
    parameter int L = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_first,
    output logic o_last
);

    localparam int CW = bs_ctr_w(L);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= '0;
        end else if (i_en && !o_last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_first = (cnt_q == '0);
    assign o_last  = (cnt_q == CW'(L - 1));

endmodule

// File: rtl/bs_word_serializer.sv
// Transmit end of the bit-serial operand link: parallel word in over
// valid/ready, LSB-first bit stream out with first/last framing and guard bits.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// BS_IDLE  | no frame; ready for a word, outputs quiet
// BS_SHIFT | frame in progress; shift register LSB is the current bit
module bs_word_serializer
    import bs_pkg::*;
#(
    parameter int WIDTH = BS_WORD_W,
    parameter int GUARD = BS_GUARD_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_signed,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_stall,
    output logic             o_bit,
    output logic             o_bit_valid,
    output logic             o_first,
    output logic             o_last,
    output logic             o_busy
);

    localparam int L = WIDTH + GUARD;

    generate
        if (WIDTH < 2 || L < 2) begin : g_bad_params
            $error("bs_word_serializer: WIDTH must be >= 2 and WIDTH+GUARD >= 2");
        end
    endgenerate

    bs_ser_state_t    state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             ext_q, ext_d;
    logic             ctr_load, ctr_en;
    logic             ctr_first, ctr_last;
    logic             shifting;
    logic             accept;

    bs_frame_ctr #(.L(L)) u_frame_ctr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (ctr_load),
        .i_en    (ctr_en),
        .o_first (ctr_first),
        .o_last  (ctr_last)
    );

    assign shifting = (state_q == BS_SHIFT);
    // Ready on the last bit lets the next word load with no idle bubble.
    assign o_ready  = !shifting || (ctr_last && !i_stall);
    assign accept   = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= BS_IDLE;
            sreg_q  <= '0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            ext_q   <= ext_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        ext_d    = ext_q;
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
        if (accept) begin
            state_d  = BS_SHIFT;
            sreg_d   = i_data;
            ext_d    = i_signed && i_data[WIDTH-1];
            ctr_load = 1'b1;
        end else if (shifting && !i_stall) begin
            if (ctr_last) begin
                state_d = BS_IDLE;
                sreg_d  = '0;
            end else begin
                // Vacated MSB takes the extension bit, so positions >= WIDTH are guard bits.
                sreg_d = {ext_q, sreg_q[WIDTH-1:1]};
                ctr_en = 1'b1;
            end
        end
    end

    assign o_bit       = shifting && sreg_q[0];
    assign o_bit_valid = shifting;
    assign o_busy      = shifting;
    assign o_first     = shifting && ctr_first;
    assign o_last      = shifting && ctr_last;

endmodule

// File: tb/tb_bs_word_serializer.sv
// Bench for bs_word_serializer: frame-level reference model checked every
// cycle, table of framed words, hand sequences and random traffic.
module tb_bs_word_serializer;

    localparam int W = 8;
    localparam int G = 8;
    localparam int L = W + G;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] i_data;
    logic         i_signed, i_valid, i_stall;
    logic         o_ready, o_bit, o_bit_valid, o_first, o_last, o_busy;

    logic [W-1:0] g_data;
    logic         g_signed, g_valid, g_stall;
    logic         g_ready, g_bit, g_bit_valid, g_first, g_last, g_busy;

    int n_checks = 0;
    int n_fail   = 0;

    bs_word_serializer #(.WIDTH(W), .GUARD(G)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_signed(i_signed),
        .i_valid(i_valid), .o_ready(o_ready), .i_stall(i_stall), .o_bit(o_bit),
        .o_bit_valid(o_bit_valid), .o_first(o_first), .o_last(o_last), .o_busy(o_busy)
    );

    bs_word_serializer #(.WIDTH(W), .GUARD(0)) dut_g0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(g_data), .i_signed(g_signed),
        .i_valid(g_valid), .o_ready(g_ready), .i_stall(g_stall), .o_bit(g_bit),
        .o_bit_valid(g_bit_valid), .o_first(g_first), .o_last(g_last), .o_busy(g_busy)
    );

    always #5 clk = ~clk;

    // Reference model: the frame is precomputed as an L-bit vector, a position index walks it.
    logic [L-1:0] m_frame;
    int           m_idx;
    logic         m_active;

    logic [63:0] cap_bits;
    int          cap_n, cap_cyc;

    function automatic logic [L-1:0] mk_frame(input logic [W-1:0] d, input logic s);
        logic [L-1:0] f;
        for (int i = 0; i < L; i++)
            f[i] = (i < W) ? d[i] : (s & d[W-1]);
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic e_ready;
        e_ready = !m_active || (m_idx == L - 1 && !i_stall);
        chk("ready", 64'(o_ready), 64'(e_ready));
        chk("bit_valid", 64'(o_bit_valid), 64'(m_active));
        chk("busy", 64'(o_busy), 64'(m_active));
        chk("bit", 64'(o_bit), 64'(m_active ? m_frame[m_idx] : 1'b0));
        chk("first", 64'(o_first), 64'(m_active && m_idx == 0));
        chk("last", 64'(o_last), 64'(m_active && m_idx == L - 1));
    endtask

    task automatic model_step();
        logic e_ready;
        e_ready = !m_active || (m_idx == L - 1 && !i_stall);
        if (!rst_n) begin
            m_active = 1'b0;
            m_idx    = 0;
        end else if (i_valid && e_ready) begin
            m_frame  = mk_frame(i_data, i_signed);
            m_idx    = 0;
            m_active = 1'b1;
        end else if (m_active && !i_stall) begin
            if (m_idx == L - 1) m_active = 1'b0;
            else m_idx++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        if (o_bit_valid) begin
            cap_cyc++;
            if (!i_stall && cap_n < 64) begin
                cap_bits[cap_n] = o_bit;
                cap_n++;
            end
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cap_clear();
        cap_bits = '0;
        cap_n    = 0;
        cap_cyc  = 0;
    endtask

    // Send one word; stall st_len cycles at bit st_at; optionally raise a foreign valid at bit ign_at.
    task automatic run_frame(input logic [W-1:0] d, input logic s, input int st_at,
                             input int st_len, input int ign_at);
        int stc, ic, guard;
        cap_clear();
        i_data = d; i_signed = s; i_valid = 1'b1; i_stall = 1'b0;
        tick();
        i_valid = 1'b0;
        i_data  = W'($urandom);
        stc = 0; ic = 0; guard = 0;
        while (cap_n < L && guard < 200) begin
            i_stall = (cap_n == st_at && stc < st_len);
            if (i_stall) stc++;
            if (ign_at >= 0 && cap_n >= ign_at && ic < 4) begin
                i_valid = 1'b1; i_data = 8'h55; ic++;
            end else begin
                i_valid = 1'b0;
            end
            tick();
            guard++;
        end
        i_stall = 1'b0;
        i_valid = 1'b0;
        if (guard >= 200) chk("frame_timeout", 64'(guard), 64'(0));
        tick();
        chk("idle_after_frame", 64'(o_bit_valid), 64'(0));
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic         s;
        int           st_at;
        int           st_len;
        logic [15:0]  exp_bits;
        int           exp_cyc;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [7:0] g_exp;

        vt[0] = '{8'hC0, 1'b1, -1, 0, 16'hFFC0, 16};
        vt[1] = '{8'hC0, 1'b0, -1, 0, 16'h00C0, 16};
        vt[2] = '{8'hA5, 1'b0,  2, 3, 16'h00A5, 19};
        vt[3] = '{8'hA5, 1'b1,  7, 1, 16'hFFA5, 17};
        vt[4] = '{8'h7F, 1'b1,  0, 2, 16'h007F, 18};
        vt[5] = '{8'h3C, 1'b0, 15, 2, 16'h003C, 18};

        rst_n = 1'b0;
        i_data = '0; i_signed = 1'b0; i_valid = 1'b0; i_stall = 1'b0;
        g_data = '0; g_signed = 1'b0; g_valid = 1'b0; g_stall = 1'b0;
        m_active = 1'b0; m_idx = 0; m_frame = '0;
        cap_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(o_ready), 64'(1));
        chk("rst_bit", 64'(o_bit), 64'(0));
        chk("rst_bit_valid", 64'(o_bit_valid), 64'(0));
        chk("rst_first", 64'(o_first), 64'(0));
        chk("rst_last", 64'(o_last), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        rst_n = 1'b1;
        tick();

        // GUARD=0 instance: 0x40 -> 0,0,0,0,0,0,1,0 with last on the MSB
        g_exp = 8'h40;
        g_valid = 1'b1; g_data = 8'h40;
        tick();
        g_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("g0_bit_valid", 64'(g_bit_valid), 64'(1));
            chk("g0_bit", 64'(g_bit), 64'(g_exp[c]));
            chk("g0_first", 64'(g_first), 64'(c == 0));
            chk("g0_last", 64'(g_last), 64'(c == 7));
            tick();
        end
        chk("g0_end_valid", 64'(g_bit_valid), 64'(0));
        chk("g0_end_ready", 64'(g_ready), 64'(1));

        for (int v = 0; v < 6; v++) begin
            run_frame(vt[v].d, vt[v].s, vt[v].st_at, vt[v].st_len, -1);
            chk($sformatf("vec%0d_bits", v), 64'(cap_bits[15:0]), 64'(vt[v].exp_bits));
            chk($sformatf("vec%0d_cycles", v), 64'(cap_cyc), 64'(vt[v].exp_cyc));
        end

        // Back-to-back: 0x01 then 0x80 with valid held, no gap between frames
        begin
            int ticks;
            cap_clear();
            i_data = 8'h01; i_signed = 1'b0; i_valid = 1'b1;
            tick();
            i_data = 8'h80;
            ticks = 0;
            while (cap_n < 2 * L && ticks < 100) begin
                tick();
                ticks++;
                if (cap_n >= L) i_valid = 1'b0;
            end
            i_valid = 1'b0;
            chk("b2b_ticks", 64'(ticks), 64'(2 * L));
            chk("b2b_cycles", 64'(cap_cyc), 64'(2 * L));
            chk("b2b_bits", 64'(cap_bits[31:0]), 64'h0080_0001);
            tick();
            chk("b2b_idle", 64'(o_bit_valid), 64'(0));
        end

        // Ignored valid mid-frame
        run_frame(8'h96, 1'b0, -1, 0, 5);
        chk("ign_bits", 64'(cap_bits[15:0]), 64'h0096);
        tick();
        chk("ign_no_frame", 64'(o_bit_valid), 64'(0));

        // Asynchronous reset at bit 4 of 0xFF
        begin
            int guard;
            cap_clear();
            i_data = 8'hFF; i_signed = 1'b0; i_valid = 1'b1;
            tick();
            i_valid = 1'b0;
            guard = 0;
            while (cap_n < 4 && guard < 50) begin
                tick();
                guard++;
            end
            chk("pre_rst_bitvalid", 64'(o_bit_valid), 64'(1));
            #2;
            rst_n = 1'b0;
            m_active = 1'b0;
            m_idx = 0;
            #1;
            chk("arst_ready", 64'(o_ready), 64'(1));
            chk("arst_bit", 64'(o_bit), 64'(0));
            chk("arst_bit_valid", 64'(o_bit_valid), 64'(0));
            chk("arst_first", 64'(o_first), 64'(0));
            chk("arst_last", 64'(o_last), 64'(0));
            chk("arst_busy", 64'(o_busy), 64'(0));
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            #2;
            chk("post_rst_ready", 64'(o_ready), 64'(1));
            tick();
            run_frame(8'h03, 1'b0, -1, 0, -1);
            chk("post_rst_bits", 64'(cap_bits[15:0]), 64'h0003);
        end

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            i_valid  = ($urandom_range(0, 2) != 0);
            i_stall  = ($urandom_range(0, 3) == 0);
            i_data   = W'($urandom);
            i_signed = 1'($urandom);
            tick();
        end
        i_valid = 1'b0;
        i_stall = 1'b0;
        repeat (L + 2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
